// File: rtl/mc_control_fsm.sv
// mc_control_fsm: main sequencer for the multi-cycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects, handshakes with the shared
// memory, and traps on illegal opcodes or a memory timeout.
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   opcode[5:0]              IR[31:26], stable after FETCH completes
//   zero                     ALU zero flag (qualifies pc_en in BRANCH)
//   mem_ready                memory accepted/completed the current access
//   mem_req, mem_write, iord memory request, write qualifier, address select
//   ir_write                 IR load (FETCH, qualified by mem_ready)
//   reg_dst, mem_to_reg,
//   reg_write                register-file address/data select, write enable
//   alu_src_a, alu_src_b,
//   alu_op                   ALU operand selects and operation
//   pc_src, pc_en            PC mux select and load enable
//   illegal_op, bus_err      sticky trap causes
//   state[3:0]               current state, for debug
module mc_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [3:0] state
);

    localparam int unsigned    CNT_W      = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic           TIMEOUT_EN = (MEM_TIMEOUT != 0);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic             wait_c;
    logic             timeout_c;

    // State, wait counter, sticky flags and Moore outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state; a timeout overrides any hold but mem_ready beats the timeout
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        wait_c    = ctrl_q.mem_req && !mem_ready;
        timeout_c = TIMEOUT_EN && wait_c && (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase

        if (timeout_c) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
        end

        // Waiting never changes state, so this also clears on a state change
        cnt_d = (wait_c && !timeout_c) ? cnt_q + 5'd1 : '0;
    end

    // Moore output decode of the state being entered, registered with it
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
            end
            S_DECODE: ctrl_d.alu_src_b = 2'b11;
            S_MEMADR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctrl_d.mem_req = 1'b1;
                ctrl_d.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b01;
                ctrl_d.pc_src    = 2'b01;
            end
            S_ADDIEX: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            S_ADDIWB: ctrl_d.reg_write = 1'b1;
            S_JUMP:   ctrl_d.pc_src = 2'b10;
            default:  ctrl_d = '0;
        endcase
    end

    // Handshake/flag-qualified outputs
    assign ir_write = (state_q == S_FETCH) && mem_ready;
    assign pc_en    = ((state_q == S_FETCH) && mem_ready)
                    || (state_q == S_JUMP)
                    || ((state_q == S_BRANCH) && zero);

    assign mem_req    = ctrl_q.mem_req;
    assign mem_write  = ctrl_q.mem_write;
    assign iord       = ctrl_q.iord;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign pc_src     = ctrl_q.pc_src;
    assign illegal_op = illegal_q;
    assign bus_err    = bus_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: instruction-level stimulus pushes one expected
// output snapshot per cycle into a queue; a monitor on the falling edge pops
// and compares against the DUT.
module tb_mc_control_fsm;

    localparam int TO = 16;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                   ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_EXEC = 7,
                   ST_ALUWB = 8, ST_BRANCH = 9, ST_ADDIEX = 10, ST_ADDIWB = 11,
                   ST_JUMP = 12, ST_TRAP = 13;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                           OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       ill;
        logic       bus;
    } exp_t;

    logic       clk, reset_n, zero, mem_ready;
    logic [5:0] opcode;
    logic       mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, illegal_op, bus_err;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    exp_t exp_q[$];
    exp_t mon_e, mon_a;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   m_ill  = 0;
    bit   m_bus  = 0;

    mc_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
        .illegal_op(illegal_op), .bus_err(bus_err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a state, from the per-state output table
    function automatic exp_t outs(input int st, input bit mr, input bit z);
        exp_t e;
        e     = '0;
        e.st  = 4'(st);
        e.ill = m_ill;
        e.bus = m_bus;
        case (st)
            ST_FETCH:  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
            ST_DECODE: e.alu_src_b = 2'b11;
            ST_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            ST_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
            ST_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            ST_MEMWR:  begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; end
            ST_EXEC:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            ST_ALUWB:  begin e.reg_write = 1; e.reg_dst = 1; end
            ST_BRANCH: begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; end
            ST_ADDIEX: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            ST_ADDIWB: e.reg_write = 1;
            ST_JUMP:   begin e.pc_src = 2'b10; e.pc_en = 1; end
            default:   ;
        endcase
        return e;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_J || op == OP_BEQ || op == OP_ADDI ||
               op == OP_LW || op == OP_SW;
    endfunction

    // One cycle: drive inputs just after the edge and queue what must be seen
    task automatic step(input int st, input bit mr, input bit z, input logic [5:0] op);
        @(posedge clk);
        #1;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        exp_q.push_back(outs(st, mr, z));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        mem_ready = 1'($urandom);
        m_ill     = 0;
        m_bus     = 0;
        exp_q.push_back(outs(ST_IDLE, 0, 0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.push_back(outs(ST_IDLE, 0, 0));
    endtask

    // A memory access with w low-ready cycles; w >= TO means it never completes
    task automatic mem_phase(input int st, input int w, input logic [5:0] op, output bit trapped);
        int lows;
        trapped = 0;
        lows = (TO != 0 && w >= TO) ? TO : w;
        for (int i = 0; i < lows; i++) step(st, 0, 1'($urandom), op);
        if (TO != 0 && w >= TO) begin
            m_bus   = 1;
            trapped = 1;
        end else begin
            step(st, 1, 1'($urandom), op);
        end
    endtask

    task automatic trap_dwell(input int n);
        for (int i = 0; i < n; i++) step(ST_TRAP, 1'(i), 1'($urandom), 6'($urandom));
        do_reset();
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit z);
        bit t;
        mem_phase(ST_FETCH, fw, 6'($urandom), t);
        if (t) begin trap_dwell(3); return; end
        step(ST_DECODE, 1'($urandom), 1'($urandom), op);
        case (op)
            OP_LW: begin
                step(ST_MEMADR, 1'($urandom), 1'($urandom), op);
                mem_phase(ST_MEMRD, mw, op, t);
                if (t) begin trap_dwell(3); return; end
                step(ST_MEMWB, 1'($urandom), 1'($urandom), op);
            end
            OP_SW: begin
                step(ST_MEMADR, 1'($urandom), 1'($urandom), op);
                mem_phase(ST_MEMWR, mw, op, t);
                if (t) begin trap_dwell(3); return; end
            end
            OP_R: begin
                step(ST_EXEC, 1'($urandom), 1'($urandom), op);
                step(ST_ALUWB, 1'($urandom), 1'($urandom), op);
            end
            OP_BEQ:  step(ST_BRANCH, 1'($urandom), z, op);
            OP_ADDI: begin
                step(ST_ADDIEX, 1'($urandom), 1'($urandom), op);
                step(ST_ADDIWB, 1'($urandom), 1'($urandom), op);
            end
            OP_J:    step(ST_JUMP, 1'($urandom), 1'($urandom), op);
            default: begin
                m_ill = 1;
                trap_dwell(4);
            end
        endcase
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 29);
        if (r == 0) return TO + $urandom_range(0, 4);
        if (r == 1) return TO - 1;
        return $urandom_range(0, 3);
    endfunction

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {state, mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
                     illegal_op, bus_err};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL ctrl @%0t exp_state=%0d: got %b required %b",
                         $time, mon_e.st, mon_a, mon_e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        int         r;
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = 6'd0;

        do_reset();
        run_instr(OP_R, 0, 0, 0);           // 0,1,2,7,8 then next fetch
        run_instr(OP_LW, 0, 3, 0);          // MEMRD held 4 cycles
        run_instr(OP_BEQ, 0, 0, 1);
        run_instr(OP_BEQ, 0, 0, 0);
        run_instr(OP_J, 0, 0, 0);
        run_instr(OP_SW, 2, 1, 0);
        run_instr(OP_ADDI, 0, 0, 0);
        run_instr(OP_R, TO - 1, 0, 0);      // ready on the last allowed cycle
        run_instr(6'b111111, 0, 0, 0);      // illegal, dwell with mem_ready toggling
        run_instr(OP_R, 40, 0, 0);          // fetch timeout
        run_instr(OP_LW, 0, TO, 0);         // data-read timeout

        // Reset during a stalled store
        step(ST_FETCH, 1, 0, 6'($urandom));
        step(ST_DECODE, 0, 0, OP_SW);
        step(ST_MEMADR, 0, 0, OP_SW);
        step(ST_MEMWR, 0, 0, OP_SW);
        step(ST_MEMWR, 0, 0, OP_SW);
        do_reset();
        run_instr(OP_R, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if      (r < 3)  op = OP_LW;
            else if (r < 6)  op = OP_SW;
            else if (r < 10) op = OP_R;
            else if (r < 13) op = OP_BEQ;
            else if (r < 16) op = OP_ADDI;
            else if (r < 19) op = OP_J;
            else begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
            run_instr(op, rand_wait(), rand_wait(), 1'($urandom));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
